// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage sequencer: EXE->MEM handshake, one data-memory transaction, WB handoff
// Sole master of the data-memory port; load/store lane alignment and load extension live here.
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_ADDR_WIDTH  = 5,
  parameter int MEM_CTRL_WIDTH = 5,
  parameter int GPR_CTRL_WIDTH = 3,
  parameter int CSR_CTRL_WIDTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      exe_valid_i,
  output logic                      exe_ready_o,
  input  logic [2*DATA_WIDTH+RF_ADDR_WIDTH+MEM_CTRL_WIDTH+GPR_CTRL_WIDTH+CSR_CTRL_WIDTH-1:0] exe2mem_i,
  input  logic                      flush_i,
  output logic                      dmem_req_o,
  input  logic                      dmem_gnt_i,
  output logic                      dmem_we_o,
  output logic [31:0]               dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [31:0]               dmem_wdata_o,
  input  logic                      dmem_rvalid_i,
  input  logic [31:0]               dmem_rdata_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [31:0]               wb_exe_out_o,
  output logic [31:0]               wb_mem_data_o,
  output logic [RF_ADDR_WIDTH-1:0]  wb_rd_o,
  output logic [GPR_CTRL_WIDTH-1:0] wb_gpr_ctrl_o,
  output logic [CSR_CTRL_WIDTH-1:0] wb_csr_ctrl_o,
  output logic                      wb_misalign_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     exe_out;
    logic [DATA_WIDTH-1:0]     op3;
    logic [RF_ADDR_WIDTH-1:0]  rd;
    logic [MEM_CTRL_WIDTH-1:0] mem_ctrl;
    logic [GPR_CTRL_WIDTH-1:0] gpr_ctrl;
    logic [CSR_CTRL_WIDTH-1:0] csr_ctrl;
  } exe2mem_t;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_HOLD, S_DRAIN} state_t;

  state_t   state_q, state_d;
  exe2mem_t pl_q, pl_d;
  logic     misalign_q, misalign_d;
  logic [31:0] mem_data_q, mem_data_d;

  exe2mem_t    in_p;
  logic [1:0]  in_op, in_size;
  logic        in_is_mem, in_misalign, accept;
  logic [1:0]  op_q, size_q, off_q;
  logic        uns_q, is_load_q, in_req;
  logic [31:0] rshift, load_ext;

  assign in_p        = exe2mem_t'(exe2mem_i);
  assign in_op       = in_p.mem_ctrl[4:3];
  assign in_size     = in_p.mem_ctrl[1:0];
  assign in_is_mem   = (in_op == 2'b01) || (in_op == 2'b10);
  // Size 11 is illegal on any memory op; misaligned accesses never reach the bus.
  assign in_misalign = in_is_mem && ((in_size == 2'b11) ||
                       ((in_size == 2'b01) && in_p.exe_out[0]) ||
                       ((in_size == 2'b10) && (in_p.exe_out[1:0] != 2'b00)));

  assign exe_ready_o = !flush_i && ((state_q == S_IDLE) || ((state_q == S_HOLD) && wb_ready_i));
  assign accept      = exe_valid_i && exe_ready_o;

  assign op_q      = pl_q.mem_ctrl[4:3];
  assign uns_q     = pl_q.mem_ctrl[2];
  assign size_q    = pl_q.mem_ctrl[1:0];
  assign off_q     = pl_q.exe_out[1:0];
  assign is_load_q = (op_q == 2'b01);

  assign rshift = dmem_rdata_i >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = {{16{~uns_q & rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pl_d       = pl_q;
    misalign_d = misalign_q;
    mem_data_d = mem_data_q;
    if (accept) begin
      pl_d       = in_p;
      misalign_d = in_misalign;
      mem_data_d = '0;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (!in_is_mem || in_misalign) ? S_HOLD : S_REQ;
      end
      S_REQ: begin
        // A granted store is already committed, so a flush only needs to drain loads.
        if (flush_i)         state_d = (dmem_gnt_i && is_load_q) ? S_DRAIN : S_IDLE;
        else if (dmem_gnt_i) state_d = is_load_q ? S_RESP : S_HOLD;
      end
      S_RESP: begin
        if (flush_i) begin
          state_d = dmem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (dmem_rvalid_i) begin
          state_d    = S_HOLD;
          mem_data_d = load_ext;
        end
      end
      S_HOLD: begin
        if (flush_i)         state_d = S_IDLE;
        else if (wb_ready_i) state_d = !accept ? S_IDLE :
                                       ((!in_is_mem || in_misalign) ? S_HOLD : S_REQ);
      end
      S_DRAIN: begin
        if (dmem_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pl_q       <= '0;
      misalign_q <= 1'b0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      pl_q       <= pl_d;
      misalign_q <= misalign_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign in_req       = (state_q == S_REQ);
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && (op_q == 2'b10);
  assign dmem_addr_o  = in_req ? {pl_q.exe_out[31:2], 2'b00} : 32'd0;
  assign dmem_wdata_o = in_req ? (pl_q.op3 << {off_q, 3'b000}) : 32'd0;
  always_comb begin
    dmem_be_o = 4'b0000;
    if (in_req) begin
      case (size_q)
        2'b00:   dmem_be_o = 4'b0001 << off_q;
        2'b01:   dmem_be_o = 4'b0011 << off_q;
        default: dmem_be_o = 4'b1111;
      endcase
    end
  end

  assign wb_valid_o    = (state_q == S_HOLD);
  assign wb_exe_out_o  = pl_q.exe_out;
  assign wb_mem_data_o = mem_data_q;
  assign wb_rd_o       = pl_q.rd;
  assign wb_gpr_ctrl_o = pl_q.gpr_ctrl;
  assign wb_csr_ctrl_o = pl_q.csr_ctrl;
  assign wb_misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
  localparam int E2M_W = 79;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic exe_valid_i = 1'b0;
  logic [E2M_W-1:0] exe2mem_i = '0;
  logic flush_i = 1'b0;
  logic dmem_gnt_i = 1'b0;
  logic dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic wb_ready_i = 1'b1;
  logic exe_ready_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_misalign_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_exe_out_o, wb_mem_data_o;
  logic [3:0] dmem_be_o;
  logic [4:0] wb_rd_o;
  logic [2:0] wb_gpr_ctrl_o;
  logic [1:0] wb_csr_ctrl_o;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .exe_valid_i(exe_valid_i), .exe_ready_o(exe_ready_o),
    .exe2mem_i(exe2mem_i), .flush_i(flush_i), .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_exe_out_o(wb_exe_out_o),
    .wb_mem_data_o(wb_mem_data_o), .wb_rd_o(wb_rd_o), .wb_gpr_ctrl_o(wb_gpr_ctrl_o),
    .wb_csr_ctrl_o(wb_csr_ctrl_o), .wb_misalign_o(wb_misalign_o)
  );

  typedef struct packed {
    logic [31:0] exe_out;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic [2:0]  gpr;
    logic        misalign;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;
  int pops  = 0;

  localparam logic [4:0] MC_NONE = 5'b00000;
  localparam logic [4:0] MC_LW   = 5'b01010;
  localparam logic [4:0] MC_LB   = 5'b01000;
  localparam logic [4:0] MC_LBU  = 5'b01100;
  localparam logic [4:0] MC_SH   = 5'b10001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [E2M_W-1:0] pk(input logic [31:0] eo, input logic [31:0] op3,
                                          input logic [4:0] rd, input logic [4:0] mc,
                                          input logic [2:0] gpr);
    return {eo, op3, rd, mc, gpr, 2'b01};
  endfunction

  task automatic expect_wb(input logic [31:0] eo, input logic [31:0] md, input logic [4:0] rd,
                           input logic [2:0] gpr, input logic mis);
    exp_t e;
    e.exe_out = eo; e.mem_data = md; e.rd = rd; e.gpr = gpr; e.misalign = mis;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // WB-side scoreboard: every WB handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst_i && wb_valid_o && wb_ready_i) begin
      tests++;
      assert (sb_q.size() > 0) else begin
        fails++;
        $error("FAIL wb_unexpected observed=%h expected=none", wb_exe_out_o);
      end
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        pops++;
        check("wb_exe_out", wb_exe_out_o, e.exe_out);
        check("wb_mem_data", wb_mem_data_o, e.mem_data);
        check("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
        check("wb_gpr_ctrl", {29'd0, wb_gpr_ctrl_o}, {29'd0, e.gpr});
        check("wb_csr_ctrl", {30'd0, wb_csr_ctrl_o}, 32'd1);
        check("wb_misalign", {31'd0, wb_misalign_o}, {31'd0, e.misalign});
      end
    end
  end

  task automatic do_load(input logic [31:0] eo, input logic [4:0] mc, input logic [31:0] rdat,
                         input logic [31:0] exp_data, input logic [3:0] exp_be, input logic [4:0] rd);
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(eo, 32'h0, rd, mc, 3'd1);
    expect_wb(eo, exp_data, rd, 3'd1, 1'b0);
    settle();
    check("ld_accept_ready", {31'd0, exe_ready_o}, 32'd1);
    cyc();
    exe_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    settle();
    check("ld_req", {31'd0, dmem_req_o}, 32'd1);
    check("ld_addr", dmem_addr_o, {eo[31:2], 2'b00});
    check("ld_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
    check("ld_we", {31'd0, dmem_we_o}, 32'd0);
    cyc();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdat;
    settle();
    check("ld_resp_no_wb", {31'd0, wb_valid_o}, 32'd0);
    cyc();
    dmem_rvalid_i = 1'b0;
    settle();
    check("ld_wb_valid_lat3", {31'd0, wb_valid_o}, 32'd1);
  endtask

  initial begin
    cyc();
    cyc();
    settle();
    check("rst_exe_ready", {31'd0, exe_ready_o}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_wb_exe_out", wb_exe_out_o, 32'd0);
    cyc();
    rst_i = 1'b0;

    do_load(32'h0000_1000, MC_LW, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 5'd1);
    do_load(32'h0000_2003, MC_LB, 32'h80FF_FF7F, 32'hFFFF_FF80, 4'b1000, 5'd2);
    do_load(32'h0000_2003, MC_LBU, 32'h80FF_FF7F, 32'h0000_0080, 4'b1000, 5'd3);

    // SH with grant delayed two cycles
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(32'h0000_3002, 32'h0000_ABCD, 5'd4, MC_SH, 3'd2);
    expect_wb(32'h0000_3002, 32'h0, 5'd4, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      exe_valid_i = 1'b0;
      dmem_gnt_i  = (i == 2);
      settle();
      check("st_req", {31'd0, dmem_req_o}, 32'd1);
      check("st_we", {31'd0, dmem_we_o}, 32'd1);
      check("st_addr", dmem_addr_o, 32'h0000_3000);
      check("st_be", {28'd0, dmem_be_o}, 32'hC);
      check("st_wdata", dmem_wdata_o, 32'hABCD_0000);
    end
    cyc();
    dmem_gnt_i = 1'b0;
    settle();
    check("st_hold_valid", {31'd0, wb_valid_o}, 32'd1);
    check("st_hold_no_req", {31'd0, dmem_req_o}, 32'd0);

    // misaligned LW
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(32'h0000_4001, 32'h0, 5'd5, MC_LW, 3'd1);
    expect_wb(32'h0000_4001, 32'h0, 5'd5, 3'd1, 1'b1);
    cyc();
    exe_valid_i = 1'b0;
    settle();
    check("mis_no_req", {31'd0, dmem_req_o}, 32'd0);
    check("mis_wb_valid", {31'd0, wb_valid_o}, 32'd1);

    // back-to-back ALU ops, WB stalls on B
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(32'hAAAA_0001, 32'h0, 5'd6, MC_NONE, 3'd0);
    expect_wb(32'hAAAA_0001, 32'h0, 5'd6, 3'd0, 1'b0);
    cyc();
    exe2mem_i = pk(32'hBBBB_0002, 32'h0, 5'd7, MC_NONE, 3'd0);
    expect_wb(32'hBBBB_0002, 32'h0, 5'd7, 3'd0, 1'b0);
    settle();
    check("alu_a_valid", {31'd0, wb_valid_o}, 32'd1);
    check("alu_ready_pipe", {31'd0, exe_ready_o}, 32'd1);
    cyc();
    wb_ready_i = 1'b0;
    exe2mem_i  = pk(32'hCCCC_0003, 32'h0, 5'd8, MC_NONE, 3'd0);
    settle();
    check("alu_b_stall_ready", {31'd0, exe_ready_o}, 32'd0);
    cyc();
    settle();
    check("alu_b_stall_ready2", {31'd0, exe_ready_o}, 32'd0);
    check("alu_b_held", wb_exe_out_o, 32'hBBBB_0002);
    cyc();
    wb_ready_i = 1'b1;
    expect_wb(32'hCCCC_0003, 32'h0, 5'd8, 3'd0, 1'b0);
    settle();
    check("alu_b_release_ready", {31'd0, exe_ready_o}, 32'd1);
    cyc();
    exe_valid_i = 1'b0;
    settle();
    check("alu_c_valid", {31'd0, wb_valid_o}, 32'd1);

    // load flushed in RESP, response arrives two cycles later
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(32'h0000_5000, 32'h0, 5'd9, MC_LW, 3'd1);
    cyc();
    exe_valid_i = 1'b0;
    dmem_gnt_i  = 1'b1;
    cyc();
    dmem_gnt_i = 1'b0;
    flush_i    = 1'b1;
    settle();
    check("fl_resp_ready", {31'd0, exe_ready_o}, 32'd0);
    cyc();
    flush_i = 1'b0;
    settle();
    check("fl_drain_ready", {31'd0, exe_ready_o}, 32'd0);
    check("fl_drain_no_req", {31'd0, dmem_req_o}, 32'd0);
    cyc();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    settle();
    check("fl_rvalid_ready", {31'd0, exe_ready_o}, 32'd0);
    check("fl_rvalid_no_wb", {31'd0, wb_valid_o}, 32'd0);
    cyc();
    dmem_rvalid_i = 1'b0;
    settle();
    check("fl_idle_ready", {31'd0, exe_ready_o}, 32'd1);
    check("fl_idle_no_wb", {31'd0, wb_valid_o}, 32'd0);
    cyc();
    exe_valid_i = 1'b1;
    exe2mem_i   = pk(32'hDDDD_0004, 32'h0, 5'd10, MC_NONE, 3'd0);
    expect_wb(32'hDDDD_0004, 32'h0, 5'd10, 3'd0, 1'b0);
    cyc();
    exe_valid_i = 1'b0;
    settle();
    check("fl_next_alu_valid", {31'd0, wb_valid_o}, 32'd1);

    cyc();
    cyc();
    settle();
    check("sb_drained", sb_q.size(), 32'd0);
    check("wb_count", pops, 32'd9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
